rr_arbiter: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource (the encoder-fed datapath slot) between requesters. It picks a winner from `req`, holds the grant until the owner releases it, drops its request, or exceeds a hold limit, then rotates priority so every requester is eventually served. It sits between the requesting agents and the shared resource and drives the resource's select and valid.

---
 rtl/rr_arbiter_if.sv | 22 ++
 rtl/rr_arbiter.sv | 86 ++++++++
 tb/tb_rr_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
// The master side raises requests; the slave side (arbiter) returns the grant.
interface rr_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]         req;
  logic                     done;
  logic [N_REQ-1:0]         gnt;
  logic [$clog2(N_REQ)-1:0] gnt_id;
  logic                     valid;
  logic                     timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, valid, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with hold-until-release grants and a hold limit.
// Priority rotates to the requester after the last owner on every release.
module rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);
  localparam int unsigned IDW = $clog2(N_REQ);
  localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gnt_id_q;
  logic [N_REQ-1:0] gnt_q;
  logic [7:0]       hold_cnt_q;
  logic             timeout_q;

  logic [IDW-1:0]   win_id;
  logic             win_vld;
  logic [IDW-1:0]   idx;
  logic             owner_req;
  logic             hold_hit;

  // Scan upward from ptr_q with wraparound; first set request wins.
  always_comb begin
    win_id  = ptr_q;
    win_vld = 1'b0;
    idx     = ptr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr_q + i[IDW-1:0];
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign owner_req = bus.req[gnt_id_q];
  assign hold_hit  = (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            gnt_q         <= '0;
            gnt_q[win_id] <= 1'b1;
            gnt_id_q      <= win_id;
            hold_cnt_q    <= '0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (bus.done || !owner_req || hold_hit) begin
            gnt_q     <= '0;
            ptr_q     <= gnt_id_q + 1'b1;
            state_q   <= IDLE;
            // Only a pure hold-limit release pulses timeout; done or a drop take precedence.
            timeout_q <= !bus.done && owner_req;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.valid   = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: reset, rotation, skip/wrap, timeout, drop,
// done-at-limit and asynchronous reset mid-grant.
module tb_rr_arbiter;
  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_fail;

  rr_arbiter_if #(.N_REQ(4)) bus ();

  rr_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit later; also check output invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    check("valid_eq_or_gnt", {31'd0, bus.valid}, {31'd0, |bus.gnt});
    check("gnt_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
  endtask

  logic [3:0] rot_gnt [4];
  int unsigned cnt;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    rot_gnt[0] = 4'b0010;
    rot_gnt[1] = 4'b0100;
    rot_gnt[2] = 4'b1000;
    rot_gnt[3] = 4'b0001;

    // Reset with all requests pending
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_gnt", {28'd0, bus.gnt}, 32'h0);
    check("rst_valid", {31'd0, bus.valid}, 32'h0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'h0);
    check("rst_gnt_id", {30'd0, bus.gnt_id}, 32'h0);
    rst = 1'b1;
    tick();
    check("first_gnt", {28'd0, bus.gnt}, 32'b0001);
    check("first_id", {30'd0, bus.gnt_id}, 32'd0);

    // Rotation 0 -> 1 -> 2 -> 3 -> 0 with one dead cycle each
    for (int i = 0; i < 4; i++) begin
      bus.done = 1'b1;
      tick();
      check("rot_dead", {31'd0, bus.valid}, 32'd0);
      bus.done = 1'b0;
      tick();
      check("rot_gnt", {28'd0, bus.gnt}, {28'd0, rot_gnt[i]});
      check("rot_id", {30'd0, bus.gnt_id}, (i + 1) % 4);
    end

    // Skip and wrap: grant 1, then ptr=2 with req=0011
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0010;
    tick();
    check("sw_gnt1", {28'd0, bus.gnt}, 32'b0010);
    bus.done = 1'b1;
    bus.req  = 4'b0011;
    tick();
    bus.done = 1'b0;
    tick();
    check("sw_wrap", {28'd0, bus.gnt}, 32'b0001);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check("sw_next", {28'd0, bus.gnt}, 32'b0010);
    bus.req = 4'b0000;
    tick();
    check("sw_drop_valid", {31'd0, bus.valid}, 32'd0);
    check("sw_drop_to", {31'd0, bus.timeout}, 32'd0);

    // Timeout after MAX_HOLD cycles with requester 2 held
    bus.req = 4'b0100;
    tick();
    check("to_gnt", {28'd0, bus.gnt}, 32'b0100);
    cnt = 0;
    for (int k = 0; k < 20 && bus.valid; k++) begin
      cnt++;
      tick();
    end
    check("to_len", cnt, 32'd8);
    check("to_pulse", {31'd0, bus.timeout}, 32'd1);
    tick();
    check("to_pulse_end", {31'd0, bus.timeout}, 32'd0);
    check("to_regrant", {28'd0, bus.gnt}, 32'b0100);

    // Owner 1 drops its request mid-grant
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0010;
    tick();
    check("drop_gnt", {28'd0, bus.gnt}, 32'b0010);
    tick();
    tick();
    check("drop_hold", {31'd0, bus.valid}, 32'd1);
    bus.req = 4'b0000;
    tick();
    check("drop_valid", {31'd0, bus.valid}, 32'd0);
    check("drop_to", {31'd0, bus.timeout}, 32'd0);
    tick();
    check("drop_to_next", {31'd0, bus.timeout}, 32'd0);

    // done coinciding with the hold limit
    bus.req = 4'b0001;
    tick();
    check("lim_gnt", {28'd0, bus.gnt}, 32'b0001);
    for (int k = 0; k < 7; k++) tick();
    check("lim_still", {31'd0, bus.valid}, 32'd1);
    bus.done = 1'b1;
    tick();
    check("lim_valid", {31'd0, bus.valid}, 32'd0);
    check("lim_to", {31'd0, bus.timeout}, 32'd0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    check("lim_to_next", {31'd0, bus.timeout}, 32'd0);

    // Asynchronous reset in the middle of a grant
    bus.req = 4'b1111;
    tick();
    check("ar_gnt", {28'd0, bus.gnt}, 32'b0010);
    #2;
    rst = 1'b0;
    #1;
    check("ar_gnt_clr", {28'd0, bus.gnt}, 32'h0);
    check("ar_valid_clr", {31'd0, bus.valid}, 32'h0);
    check("ar_id_clr", {30'd0, bus.gnt_id}, 32'h0);
    bus.req = 4'b1000;
    #1;
    rst = 1'b1;
    tick();
    check("ar_after_gnt", {28'd0, bus.gnt}, 32'b1000);
    check("ar_after_id", {30'd0, bus.gnt_id}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
